// File: rtl/sfq_ha_link_driver.sv
// sfq_ha_link_driver
//   Host-side driver for the toggle-encoded SFQ half-adder link. It accepts an
//   operand pair, pulses a_tog/b_tog (one level flip per asserted operand),
//   fires one SFQ clock flip on sclk_tog, then counts the toggles that come
//   back on s_tog/cout_tog during a fixed window. The decoded result is
//   checked against the expected half-adder result.
//
// Ports
//   clk, rst                 system clock (rising edge), async active-high reset
//   in_valid/in_ready        operand handshake; in_a, in_b are the operands
//   a_tog, b_tog, sclk_tog   toggle-encoded pulse lines toward the half-adder
//   s_tog, cout_tog          asynchronous toggle-encoded returns
//   out_valid/out_ready      result handshake
//   out_s, out_cout          decoded result bits
//   out_dbl                  more than one toggle seen on a return channel
//   out_mismatch             decoded result differs from expected, or out_dbl
//   stray_err                sticky: a return toggle arrived outside a window
//
// state | meaning
// IDLE  | ready for an operand pair
// SETUP | a/b pulses sent, waiting SETUP_CYC before the SFQ clock
// FIRE  | flip sclk_tog, clear counts, arm the window timer
// WAIT  | counting returned toggles for WINDOW_CYC cycles
// DONE  | result presented until the consumer accepts it

module sfq_ha_link_driver #(
   parameter int unsigned SETUP_CYC   = 4,
   parameter int unsigned WINDOW_CYC  = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic in_valid,
   output logic in_ready,
   input  logic in_a,
   input  logic in_b,
   output logic a_tog,
   output logic b_tog,
   output logic sclk_tog,
   input  logic s_tog,
   input  logic cout_tog,
   output logic out_valid,
   input  logic out_ready,
   output logic out_s,
   output logic out_cout,
   output logic out_dbl,
   output logic out_mismatch,
   output logic stray_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_FIRE  = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [7:0] tmr;
   logic [7:0] mask_cnt;
   logic [SYNC_STAGES-1:0] s_sync, c_sync;
   logic s_prev, c_prev;
   logic s_det, c_det;
   logic [1:0] s_cnt, c_cnt;
   logic exp_a, exp_b;
   logic hs_in, hs_out;
   logic masked;

   assign hs_in  = in_valid && in_ready;
   assign hs_out = out_valid && out_ready;
   assign masked = (mask_cnt != 8'd0);

   // Return-line synchronizers and registered edge detect. Detect is one
   // cycle behind the synchronizer output, so total latency is
   // SYNC_STAGES+1 cycles from the input change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_sync <= '0;
         c_sync <= '0;
         s_prev <= 1'b0;
         c_prev <= 1'b0;
         s_det  <= 1'b0;
         c_det  <= 1'b0;
      end else begin
         s_sync <= {s_sync[SYNC_STAGES-2:0], s_tog};
         c_sync <= {c_sync[SYNC_STAGES-2:0], cout_tog};
         s_prev <= s_sync[SYNC_STAGES-1];
         c_prev <= c_sync[SYNC_STAGES-1];
         // While masked, prev still tracks the synchronizer so a line that
         // sat high through reset does not look like an edge afterwards.
         s_det  <= !masked && (s_sync[SYNC_STAGES-1] ^ s_prev);
         c_det  <= !masked && (c_sync[SYNC_STAGES-1] ^ c_prev);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mask_cnt <= 8'(SYNC_STAGES + 1);
      else if (masked)
         mask_cnt <= mask_cnt - 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (hs_in) state_nxt = S_SETUP;
         S_SETUP: if (tmr == 8'd0) state_nxt = S_FIRE;
         S_FIRE:  state_nxt = S_WAIT;
         S_WAIT:  if (tmr == 8'd0) state_nxt = S_DONE;
         S_DONE:  if (hs_out) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready     = (state == S_IDLE);
      out_valid    = (state == S_DONE);
      out_s        = (s_cnt != 2'd0);
      out_cout     = (c_cnt != 2'd0);
      out_dbl      = (s_cnt == 2'd2) || (c_cnt == 2'd2);
      out_mismatch = out_dbl || (out_s != (exp_a ^ exp_b)) || (out_cout != (exp_a & exp_b));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr      <= 8'd0;
         a_tog    <= 1'b0;
         b_tog    <= 1'b0;
         sclk_tog <= 1'b0;
         exp_a    <= 1'b0;
         exp_b    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (hs_in) begin
                  exp_a <= in_a;
                  exp_b <= in_b;
                  a_tog <= a_tog ^ in_a;
                  b_tog <= b_tog ^ in_b;
                  tmr   <= 8'(SETUP_CYC - 1);
               end
            end
            S_SETUP: if (tmr != 8'd0) tmr <= tmr - 8'd1;
            S_FIRE: begin
               sclk_tog <= !sclk_tog;
               tmr      <= 8'(WINDOW_CYC - 1);
            end
            S_WAIT:  if (tmr != 8'd0) tmr <= tmr - 8'd1;
            default: ;
         endcase
      end
   end

   // Per-channel return counts, saturating at 2 (2 means "more than one").
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_cnt <= 2'd0;
         c_cnt <= 2'd0;
      end else if (state == S_FIRE) begin
         s_cnt <= 2'd0;
         c_cnt <= 2'd0;
      end else if (state == S_WAIT) begin
         if (s_det && s_cnt != 2'd2) s_cnt <= s_cnt + 2'd1;
         if (c_det && c_cnt != 2'd2) c_cnt <= c_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stray_err <= 1'b0;
      else if ((s_det || c_det) && state != S_WAIT)
         stray_err <= 1'b1;
   end

endmodule

// File: tb/tb_sfq_ha_link_driver.sv
module tb_sfq_ha_link_driver;

   localparam int SETUP_CYC   = 4;
   localparam int WINDOW_CYC  = 16;
   localparam int SYNC_STAGES = 2;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_ready, in_a, in_b;
   logic a_tog, b_tog, sclk_tog;
   logic s_tog, cout_tog;
   logic out_valid, out_ready;
   logic out_s, out_cout, out_dbl, out_mismatch, stray_err;

   sfq_ha_link_driver #(
      .SETUP_CYC(SETUP_CYC), .WINDOW_CYC(WINDOW_CYC), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .a_tog(a_tog), .b_tog(b_tog), .sclk_tog(sclk_tog),
      .s_tog(s_tog), .cout_tog(cout_tog),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_cout(out_cout), .out_dbl(out_dbl),
      .out_mismatch(out_mismatch), .stray_err(stray_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit s;
      bit cout;
      bit dbl;
      bit mism;
   } res_t;

   res_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   bit   m_a, m_b, m_sclk, m_stray;
   int   sclk_flips = 0;
   logic sclk_last = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   // Result monitor: compares whenever the DUT hands a result over.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("out_s", out_s, e.s);
            chk("out_cout", out_cout, e.cout);
            chk("out_dbl", out_dbl, e.dbl);
            chk("out_mismatch", out_mismatch, e.mism);
         end
      end
   end

   always @(negedge clk) begin
      if (sclk_tog !== sclk_last) sclk_flips++;
      sclk_last = sclk_tog;
   end

   function automatic res_t model(input bit a, input bit b, input int ns, input int nc);
      res_t r;
      r.s    = (ns != 0);
      r.cout = (nc != 0);
      r.dbl  = (ns >= 2) || (nc >= 2);
      r.mism = r.dbl || (r.s != (a ^ b)) || (r.cout != (a & b));
      return r;
   endfunction

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("rst_a_tog", a_tog, 0);
      chk("rst_b_tog", b_tog, 0);
      chk("rst_sclk_tog", sclk_tog, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_stray", stray_err, 0);
      exp_q.delete();
      m_a = 0; m_b = 0; m_sclk = 0; m_stray = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // One transaction: handshake, check pulse lines and sclk timing, return
   // ns/nc toggles starting d0 cycles after sclk, optionally stall out_ready.
   task automatic run_txn(input bit a, input bit b, input int ns, input int nc,
                          input int d0, input int hold, input bit pre_s, input bit abort);
      int k;
      bit ok;
      res_t e;
      @(posedge clk); #1;
      in_valid = 1'b1; in_a = a; in_b = b;
      k = 0;
      while (in_ready !== 1'b1 && k < 200) begin
         @(posedge clk); #1; k++;
      end
      if (k == 200) begin
         chk("in_ready_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = (hold == 0);
      e = model(a, b, ns, nc);
      if (!abort) exp_q.push_back(e);
      if (a) m_a = !m_a;
      if (b) m_b = !m_b;
      chk("a_tog", a_tog, m_a);
      chk("b_tog", b_tog, m_b);
      chk("in_ready_busy", in_ready, 0);
      if (pre_s) begin
         s_tog = !s_tog;
         m_stray = 1;
      end
      k = 0; ok = 0;
      while (k < 50 && !ok) begin
         @(posedge clk); #1; k++;
         if (sclk_tog !== m_sclk) ok = 1;
      end
      m_sclk = !m_sclk;
      chk("sclk_flip_cycle", k, SETUP_CYC + 1);
      repeat (d0) begin @(posedge clk); #1; end
      for (int i = 0; i < ns || i < nc; i++) begin
         if (i < ns) s_tog = !s_tog;
         if (i < nc) cout_tog = !cout_tog;
         @(posedge clk); #1;
      end
      if (abort) begin
         if (s_tog == 1'b0) s_tog = 1'b1;
         @(posedge clk); #1;
         chk("a_tog_before_rst", a_tog, 1);
         do_reset();
         return;
      end
      if (hold > 0) begin
         k = 0;
         while (out_valid !== 1'b1 && k < 100) begin
            @(posedge clk); #1; k++;
         end
         chk("out_valid_arrives", out_valid, 1);
         for (int j = 0; j < hold; j++) begin
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_s", out_s, e.s);
            chk("hold_out_cout", out_cout, e.cout);
            chk("hold_a_tog", a_tog, m_a);
            @(posedge clk); #1;
         end
         out_ready = 1'b1;
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(posedge clk); k++;
      end
      chk("drain", exp_q.size(), 0);
      @(posedge clk); #1;
      chk("in_ready_after", in_ready, 1);
      chk("sclk_level", sclk_tog, m_sclk);
      chk("stray_err", stray_err, m_stray);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      bit ra, rb;
      int ns, nc;
      rst = 1'b1;
      in_valid = 0; in_a = 0; in_b = 0;
      s_tog = 0; cout_tog = 0; out_ready = 1;
      m_a = 0; m_b = 0; m_sclk = 0; m_stray = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("init_in_ready", in_ready, 1);
      chk("init_out_valid", out_valid, 0);
      chk("init_a_tog", a_tog, 0);
      chk("init_sclk_tog", sclk_tog, 0);
      chk("init_stray", stray_err, 0);
      chk("init_mismatch", out_mismatch, 0);
      rst = 1'b0;
      repeat (5) @(posedge clk);

      run_txn(1, 1, 0, 1, 5, 0, 0, 0);
      drain();
      run_txn(1, 0, 2, 0, 1, 0, 0, 0);
      drain();
      run_txn(0, 0, 0, 0, 0, 10, 0, 0);
      drain();

      f0 = sclk_flips;
      run_txn(1, 0, 1, 0, 2, 0, 0, 0);
      run_txn(0, 1, 1, 0, 0, 0, 0, 0);
      run_txn(1, 1, 0, 1, 3, 0, 0, 0);
      drain();
      chk("b2b_sclk_flips", sclk_flips - f0, 3);

      for (int t = 0; t < 40; t++) begin
         ra = 1'($urandom_range(0, 1));
         rb = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0) begin
            ns = int'(ra ^ rb);
            nc = int'(ra & rb);
         end else begin
            ns = $urandom_range(0, 3);
            nc = $urandom_range(0, 3);
         end
         run_txn(ra, rb, ns, nc, $urandom_range(0, 5),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 0, 0);
      end
      drain();

      run_txn(1, 0, 0, 0, 2, 0, 1, 0);
      drain();

      run_txn(!m_a, 0, 1, 0, 1, 0, 0, 1);
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_stray", stray_err, 0);
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);
      run_txn(0, 0, 0, 0, 0, 0, 0, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
